// File: rtl/frame_tx_sequencer.sv
// frame_tx_sequencer: sends a fixed 4-byte ON/OFF command frame to the UART TX byte engine,
// with per-byte handshake, optional inter-byte gap, one-deep request queue and stall timeout.
module frame_tx_sequencer #(
  parameter int GAP_CYCLES = 0,
  parameter int TIMEOUT    = 50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_on,
  input  logic       req_off,
  input  logic       tx_done,
  output logic [7:0] tx_data,
  output logic       tx_flag,
  output logic       busy,
  output logic       done,
  output logic       err
);
  typedef enum logic [2:0] {IDLE, LOAD, WAIT_DONE, GAP, FINISH} state_t;
  localparam logic [15:0] TO_LIM   = 16'(TIMEOUT);
  localparam logic [15:0] GAP_LAST = 16'(GAP_CYCLES - 1);
  state_t      state, state_n;
  logic [1:0]  idx, idx_n;
  logic        on, on_n, pend_v, pend_v_n, pend_on, pend_on_n;
  logic [15:0] cnt, cnt_n;
  logic        req;
  assign req = req_on | req_off;
  // ON bytes are AA+11*i, OFF bytes are 55+11*i
  function automatic logic [7:0] frame_byte(input logic sel_on, input logic [1:0] i);
    return (sel_on ? 8'hAA : 8'h55) + 8'h11 * {6'd0, i};
  endfunction
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      idx     <= 2'd0;
      on      <= 1'b0;
      pend_v  <= 1'b0;
      pend_on <= 1'b0;
      cnt     <= 16'd0;
      tx_data <= 8'h00;
    end else begin
      state   <= state_n;
      idx     <= idx_n;
      on      <= on_n;
      pend_v  <= pend_v_n;
      pend_on <= pend_on_n;
      cnt     <= cnt_n;
      if (state_n == LOAD) tx_data <= frame_byte(on_n, idx_n);
    end
  end
  always_comb begin
    state_n   = state;
    idx_n     = idx;
    on_n      = on;
    pend_v_n  = pend_v;
    pend_on_n = pend_on;
    cnt_n     = cnt;
    tx_flag   = 1'b0;
    done      = 1'b0;
    err       = 1'b0;
    busy      = state != IDLE;
    if (state != IDLE && req) begin
      pend_v_n  = 1'b1;
      pend_on_n = req_on;
    end
    case (state)
      IDLE: if (req) begin
        state_n = LOAD;
        on_n    = req_on;
        idx_n   = 2'd0;
      end
      LOAD: begin
        tx_flag = 1'b1;
        state_n = WAIT_DONE;
        cnt_n   = 16'd0;
      end
      WAIT_DONE: if (tx_done) begin
        cnt_n = 16'd0;
        if (idx == 2'd3) state_n = FINISH;
        else begin
          idx_n   = idx + 2'd1;
          state_n = (GAP_CYCLES > 0) ? GAP : LOAD;
        end
      end else if (cnt == TO_LIM) begin
        err      = 1'b1;
        state_n  = IDLE;
        pend_v_n = 1'b0;
      end else cnt_n = cnt + 16'd1;
      GAP: begin
        state_n = (cnt == GAP_LAST) ? LOAD : GAP;
        cnt_n   = (cnt == GAP_LAST) ? 16'd0 : cnt + 16'd1;
      end
      FINISH: begin
        // a request arriving in this very cycle is the newest, so it beats the stored one
        done     = 1'b1;
        state_n  = (req || pend_v) ? LOAD : IDLE;
        on_n     = req ? req_on : pend_on;
        idx_n    = 2'd0;
        pend_v_n = 1'b0;
      end
      default: state_n = IDLE;
    endcase
  end
endmodule

// File: tb/tb_frame_tx_sequencer.sv
// tb_frame_tx_sequencer: two instances (gap 0 and gap 3, timeout 20) checked every cycle against
// a timestamp-based model of the frame protocol, plus hand-computed latency/byte checks.
module tb_frame_tx_sequencer;
  localparam int TO = 20;
  localparam logic [7:0] ON_B  [4] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
  localparam logic [7:0] OFF_B [4] = '{8'h55, 8'h66, 8'h77, 8'h88};
  logic clk, rst_n, req_on, req_off;
  logic tx_done [2];
  logic [7:0] tx_data [2];
  logic tx_flag [2], busy [2], done [2], err [2];
  int cyc, nchk, nfail, rq;
  bit act [2], waiting [2], mon [2], pend [2], pon [2];
  int nb [2], nxt [2], fcyc [2], done_at [2];
  logic [7:0] mdat [2];
  logic [31:0] seen [2];
  int nflag [2], ndone [2], nerr [2], last_done [2], last_err [2];
  bit saw55 [2];
  int due [2], ans [2], dly [2];

  frame_tx_sequencer #(.GAP_CYCLES(0), .TIMEOUT(TO)) dut0 (
    .clk(clk), .rst_n(rst_n), .req_on(req_on), .req_off(req_off), .tx_done(tx_done[0]),
    .tx_data(tx_data[0]), .tx_flag(tx_flag[0]), .busy(busy[0]), .done(done[0]), .err(err[0]));
  frame_tx_sequencer #(.GAP_CYCLES(3), .TIMEOUT(TO)) dut3 (
    .clk(clk), .rst_n(rst_n), .req_on(req_on), .req_off(req_off), .tx_done(tx_done[1]),
    .tx_data(tx_data[1]), .tx_flag(tx_flag[1]), .busy(busy[1]), .done(done[1]), .err(err[1]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int g, input int a, input int e);
    nchk++;
    if (a !== e) begin
      nfail++;
      $display("FAIL %s inst%0d cycle %0d: got %0h expected %0h", nm, g, cyc, a, e);
    end
  endtask

  task automatic clr();
    for (int g = 0; g < 2; g++) begin
      seen[g] = 0; nflag[g] = 0; ndone[g] = 0; nerr[g] = 0;
      last_done[g] = -1; last_err[g] = -1; saw55[g] = 0;
    end
  endtask

  // one clock cycle: compare at negedge, then advance inputs just after posedge
  task automatic tick();
    bit ef, edn, eer, r;
    @(negedge clk);
    r = req_on | req_off;
    for (int g = 0; g < 2; g++) begin
      ef = 0; edn = 0; eer = 0;
      if (!rst_n) begin
        act[g] = 0; waiting[g] = 0; pend[g] = 0; mdat[g] = 8'h00; nxt[g] = -1; done_at[g] = -1;
      end else begin
        ef = act[g] && nxt[g] == cyc;
        if (ef) mdat[g] = mon[g] ? ON_B[nb[g]] : OFF_B[nb[g]];
        edn = act[g] && done_at[g] == cyc;
        eer = act[g] && waiting[g] && cyc == fcyc[g] + 1 + TO && !tx_done[g];
      end
      chk("tx_flag", g, int'(tx_flag[g]), int'(ef));
      chk("tx_data", g, int'(tx_data[g]), int'(mdat[g]));
      chk("busy", g, int'(busy[g]), int'(act[g]));
      chk("done", g, int'(done[g]), int'(edn));
      chk("err", g, int'(err[g]), int'(eer));
      if (tx_flag[g] === 1'b1) begin
        seen[g] = {seen[g][23:0], tx_data[g]};
        nflag[g]++;
        if (tx_data[g] == 8'h55) saw55[g] = 1;
      end
      if (done[g] === 1'b1) begin ndone[g]++; last_done[g] = cyc; end
      if (err[g] === 1'b1) begin nerr[g]++; last_err[g] = cyc; end
      if (rst_n) begin
        if (ef) begin
          waiting[g] = 1; fcyc[g] = cyc; nxt[g] = -1;
        end else if (waiting[g] && tx_done[g]) begin
          waiting[g] = 0;
          if (nb[g] == 3) done_at[g] = cyc + 1;
          else begin nb[g]++; nxt[g] = cyc + 1 + 3 * g; end
        end
        if (eer) begin
          act[g] = 0; waiting[g] = 0; pend[g] = 0;
        end else if (edn) begin
          done_at[g] = -1;
          if (r || pend[g]) begin mon[g] = r ? req_on : pon[g]; nb[g] = 0; nxt[g] = cyc + 1; end
          else act[g] = 0;
          pend[g] = 0;
        end else if (r) begin
          if (!act[g]) begin act[g] = 1; mon[g] = req_on; nb[g] = 0; nxt[g] = cyc + 1; done_at[g] = -1; end
          else begin pend[g] = 1; pon[g] = req_on; end
        end
      end
    end
    @(posedge clk); #1;
    cyc++;
    req_on = 0; req_off = 0;
    for (int g = 0; g < 2; g++) begin
      if (tx_flag[g] && ans[g] > 0) begin
        due[g] = cyc + (dly[g] > 0 ? dly[g] : int'($urandom_range(1, 24)));
        ans[g]--;
      end
      tx_done[g] = rst_n && cyc == due[g];
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy[0] || busy[1]) && n < 600) begin tick(); n++; end
    nchk++;
    if (n >= 600) begin nfail++; $display("FAIL wait_idle cycle %0d: still busy after %0d cycles, required idle", cyc, n); end
    tick(); tick();
  endtask

  task automatic set_dly(input int d);
    for (int g = 0; g < 2; g++) begin dly[g] = d; ans[g] = 1 << 30; end
  endtask

  initial begin
    rst_n = 0; req_on = 0; req_off = 0; cyc = 0; nchk = 0; nfail = 0;
    for (int g = 0; g < 2; g++) begin tx_done[g] = 0; due[g] = -1; end
    set_dly(10);
    @(posedge clk); #1;
    repeat (3) tick();
    rst_n = 1;
    tick();
    set_dly(1); clr();
    req_on = 1; rq = cyc; tick(); wait_idle();
    chk("min_latency", 0, last_done[0] - rq, 9);
    chk("min_latency", 1, last_done[1] - rq, 18);
    chk("min_bytes", 0, seen[0], 32'hAABBCCDD);
    set_dly(10); clr();
    req_on = 1; rq = cyc; tick(); wait_idle();
    chk("on_latency", 0, last_done[0] - rq, 45);
    chk("on_latency", 1, last_done[1] - rq, 54);
    chk("on_bytes", 0, seen[0], 32'hAABBCCDD);
    chk("on_bytes", 1, seen[1], 32'hAABBCCDD);
    chk("on_noerr", 0, nerr[0], 0);
    clr();
    req_on = 1; req_off = 1; tick(); wait_idle();
    chk("both_bytes", 0, seen[0], 32'hAABBCCDD);
    chk("both_flags", 1, nflag[1], 4);
    clr();
    req_on = 1; tick(); repeat (5) tick();
    req_off = 1; tick(); repeat (5) tick();
    req_on = 1; tick(); wait_idle();
    chk("pend_flags", 0, nflag[0], 8);
    chk("pend_no55", 0, int'(saw55[0]), 0);
    chk("pend_done", 1, ndone[1], 2);
    clr();
    req_off = 1; rq = cyc; tick(); wait_idle();
    chk("off_latency", 1, last_done[1] - rq, 54);
    chk("off_bytes", 1, seen[1], 32'h55667788);
    chk("off_bytes", 0, seen[0], 32'h55667788);
    clr();
    for (int g = 0; g < 2; g++) ans[g] = 0;
    req_on = 1; rq = cyc; tick(); repeat (4) tick();
    req_on = 1; tick(); wait_idle();
    chk("to_err_cycle", 0, last_err[0] - rq, 22);
    chk("to_err_cycle", 1, last_err[1] - rq, 22);
    chk("to_flags", 0, nflag[0], 1);
    chk("to_nodone", 1, ndone[1], 0);
    set_dly(10); clr();
    req_on = 1; tick();
    for (int n = 0; n < 100 && nflag[1] < 3; n++) tick();
    repeat (3) tick();
    rst_n = 0; #1;
    for (int g = 0; g < 2; g++) begin
      chk("rst_flag", g, int'(tx_flag[g]), 0);
      chk("rst_data", g, int'(tx_data[g]), 0);
      chk("rst_busy", g, int'(busy[g]), 0);
      chk("rst_done_err", g, int'(done[g] | err[g]), 0);
    end
    tick(); tick();
    rst_n = 1;
    for (int g = 0; g < 2; g++) begin due[g] = -1; tx_done[g] = 0; end
    clr();
    req_on = 1; tick(); wait_idle();
    chk("post_rst_bytes", 0, seen[0], 32'hAABBCCDD);
    chk("post_rst_bytes", 1, seen[1], 32'hAABBCCDD);
    chk("post_rst_done", 0, ndone[0], 1);
    set_dly(0);
    repeat (3000) begin
      int r = int'($urandom_range(0, 29));
      req_on = (r == 0 || r == 2);
      req_off = (r == 1 || r == 2);
      tick();
    end
    wait_idle();
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end
endmodule

// File: doc/frame_tx_sequencer.md
# frame_tx_sequencer

Command-frame transmitter for the UART control path. On a one-cycle request it emits a fixed 4-byte frame, one byte at a time, to the UART byte transmitter: AA BB CC DD for "LEDs on", 55 66 77 88 for "LEDs off". It is the sending end of the same frame protocol the LED board decodes. It sits between the key/command logic and the UART TX byte engine, and handles per-byte handshake, inter-byte gap, one-deep request queuing and a stall timeout.

## Interface
- GAP_CYCLES, 0: idle cycles inserted after each byte's tx_done before the next byte (not after the last byte); 0..65535
- TIMEOUT, 50000: max cycles spent waiting for tx_done per byte before abort; 1..65535
- clk  input  1  system clock; the only clock
- rst_n  input  1  reset, asynchronous assert, active-low
- req_on  input  1  one-cycle pulse: send frame AA BB CC DD
- req_off  input  1  one-cycle pulse: send frame 55 66 77 88
- tx_done  input  1  one-cycle pulse from UART TX: current byte fully shifted out
- tx_data  output  8  byte to transmit; valid with tx_flag, held until the next tx_flag
- tx_flag  output  1  one-cycle start pulse to UART TX
- busy  output  1  high while a frame is in progress (all states except IDLE)
- done  output  1  one-cycle pulse: frame completed successfully
- err  output  1  one-cycle pulse: frame aborted on timeout

## Operation
- Reset values: tx_data=8'h00, tx_flag=0, busy=0, done=0, err=0. State=IDLE, byte index=0, pending empty, counters=0.
- Frame type: ON selects bytes [AA,BB,CC,DD]; OFF selects [55,66,77,88]. Byte index runs 0..3 and is 2 bits wide.
- States:
  - IDLE: on req_on or req_off, latch the type and go to LOAD with index=0. If both arrive in the same cycle, ON wins.
  - LOAD (1 cycle): tx_flag=1, tx_data=frame[index]; go to WAIT_DONE; clear the timeout counter.
  - WAIT_DONE: wait for tx_done.
    - On tx_done with index<3: go to GAP if GAP_CYCLES>0, else LOAD, with index+1.
    - On tx_done with index==3: go to FINISH.
    - Counter increments each cycle without tx_done. When it reaches TIMEOUT, pulse err, drop pending, go to IDLE.
  - GAP: count GAP_CYCLES cycles, then go to LOAD.
  - FINISH (1 cycle): done=1. If pending is valid, go to LOAD with the pending type, index=0, and clear pending. Otherwise go to IDLE.
- Pending: a request arriving in any non-IDLE state is stored in a one-deep slot. A later request overwrites it (last wins); on a same-cycle collision ON wins. A request in the same cycle as an err abort is discarded.
- tx_done outside WAIT_DONE is ignored.
- Reset mid-frame: every output returns to its reset value immediately. No partial-frame completion and no done/err on reset.

## Timing
- Request sampled in cycle k: tx_flag and first byte in cycle k+1.
- tx_done in cycle m, index<3: next tx_flag in cycle m+1 when GAP_CYCLES=0, or in cycle m+1+GAP_CYCLES otherwise.
- Last tx_done in cycle m: done in cycle m+1. busy falls in cycle m+2 if nothing is pending. If a request is pending, the next tx_flag is in cycle m+2 and busy stays high.
- Timeout: tx_flag in cycle t with no tx_done: err in cycle t+1+TIMEOUT, and busy low from the following cycle.
- Minimum frame length with GAP_CYCLES=0 and tx_done returned 1 cycle after each tx_flag: 9 cycles from request to done.
- tx_flag is never high on consecutive cycles. done and err are mutually exclusive.

## Test plan
- Pulse req_on, UART model returns tx_done 10 cycles after each tx_flag, GAP_CYCLES=0 -> tx_flag ×4 carrying AA, BB, CC, DD; done 1 cycle after the 4th tx_done; err never asserts.
- req_on and req_off in the same cycle -> frame AA BB CC DD only; no pending frame follows.
- During an ON frame, pulse req_off then req_on -> after done, one more ON frame starts 1 cycle later with busy continuously high; 55 never appears.
- GAP_CYCLES=3, req_off -> bytes 55, 66, 77, 88, with each tx_flag exactly 4 cycles after the previous tx_done.
- TIMEOUT=20, withhold tx_done after the first byte -> err exactly 21 cycles after that tx_flag; busy low the next cycle; done never asserts; a req_on issued before the abort is not sent.
- Assert rst_n=0 while waiting on byte CC -> all outputs 0 immediately; after release, req_on sends a clean AA BB CC DD frame.
